// File: rtl/uart_tx_parity_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_parity_if
// Purpose  : Byte handshake between host logic and the UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_parity_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_parity.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_parity
// Purpose  : UART transmitter, 8 data bits, even parity, 1 stop bit, LSB first.
//            Define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry FIFO in front.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_parity #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic        clk,
    input  wire logic        reset,
    uart_tx_parity_if.slave  host,
    output logic             tx,
    output logic             tx_busy,
    output logic             tx_done
);

    localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam logic [15:0] c_last_cnt   = 16'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
        $error("uart_tx_parity: illegal CLKS_PER_BIT or FIFO_DEPTH");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_clk_cnt;
    logic [15:0] w_clk_cnt_next;
    logic [2:0]  r_bit_idx;
    logic [2:0]  w_bit_idx_next;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift_next;
    logic        r_tx;
    logic        w_tx_next;
    logic        w_bit_end;
    logic        w_load;
    logic        w_byte_avail;
    logic [7:0]  w_byte_in;

`ifdef UART_TX_FIFO_EN
    localparam int                 c_ptr_w     = $clog2(FIFO_DEPTH);
    localparam logic [c_ptr_w:0]   c_fifo_full = (c_ptr_w + 1)'(FIFO_DEPTH);

    logic [7:0]         r_fifo [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_full;
    logic               w_push;

    assign w_full        = (r_count == c_fifo_full);
    assign host.tx_ready = !w_full;
    assign w_push        = host.tx_valid && !w_full;
    assign w_byte_avail  = (r_count != '0);
    assign w_byte_in     = r_fifo[r_rd_ptr];

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_load) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_load)      r_count <= r_count + 1'b1;
            else if (w_load && !w_push) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= host.tx_data;
    end
`else
    assign host.tx_ready = (r_state == S_IDLE);
    assign w_byte_avail  = host.tx_valid;
    assign w_byte_in     = host.tx_data;
`endif

    assign w_bit_end = (r_clk_cnt == c_last_cnt);

    always_comb begin
        w_state_next   = r_state;
        w_clk_cnt_next = r_clk_cnt;
        w_bit_idx_next = r_bit_idx;
        w_load         = 1'b0;

        if (r_state == S_IDLE) begin
            w_clk_cnt_next = '0;
            w_bit_idx_next = '0;
            if (w_byte_avail) begin
                w_state_next = S_START;
                w_load       = 1'b1;
            end
        end else begin
            w_clk_cnt_next = w_bit_end ? 16'd0 : r_clk_cnt + 16'd1;
            case (r_state)
                S_START: begin
                    if (w_bit_end) begin
                        w_state_next   = S_DATA;
                        w_bit_idx_next = '0;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == 3'd7) w_state_next   = S_PARITY;
                        else                   w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) w_state_next = S_STOP;
                end
                S_STOP: begin
                    if (w_bit_end) begin
`ifdef UART_TX_FIFO_EN
                        // Chain straight into the next frame when a byte is queued.
                        if (w_byte_avail) begin
                            w_state_next = S_START;
                            w_load       = 1'b1;
                        end else begin
                            w_state_next = S_IDLE;
                        end
`else
                        w_state_next = S_IDLE;
`endif
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end

        w_shift_next = w_load ? w_byte_in : r_shift;

        // Line level is computed from the upcoming state so tx stays registered.
        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shift_next[w_bit_idx_next];
            S_PARITY: w_tx_next = ^w_shift_next;
            default:  w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_clk_cnt <= w_clk_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_tx      <= w_tx_next;
        end
    end

    assign tx      = r_tx;
    assign tx_busy = (r_state != S_IDLE);
    assign tx_done = (r_state == S_STOP) && w_bit_end;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_parity.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_parity
// Purpose  : Self-checking bench for uart_tx_parity (CLKS_PER_BIT = 10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_parity;

`ifdef UART_TX_FIFO_EN
    localparam bit c_fifo = 1'b1;
`else
    localparam bit c_fifo = 1'b0;
`endif
    localparam int c_bit_clks   = 10;
    localparam int c_frame_clks = 11 * c_bit_clks;

    typedef struct {
        logic [7:0] data;
        logic       exp_par;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } rx_rec_t;

    logic    clk;
    logic    reset;
    logic    tx;
    logic    tx_busy;
    logic    tx_done;
    int      n_checks;
    int      n_fail;
    rx_rec_t rx_q[$];

    uart_tx_parity_if bus ();

    uart_tx_parity #(
        .CLK_FREQ   (1000),
        .BAUD_RATE  (100),
        .FIFO_DEPTH (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .host    (bus),
        .tx      (tx),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Independent line receiver: samples mid-bit, pushes each decoded frame.
    initial begin
        int         k;
        logic [7:0] d;
        logic       p;
        k = 0;
        d = '0;
        p = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                k = 0;
            end else if (k == 0) begin
                if (tx == 1'b0) k = 1;
            end else begin
                k++;
                if (k == 5 && tx != 1'b0) k = 0;
                else if (k >= 15 && k <= 85 && (k - 15) % 10 == 0) d[(k - 15) / 10] = tx;
                else if (k == 95) p = tx;
                else if (k == 105) begin
                    rx_q.push_back('{data: d, perr: p ^ (^d), ferr: (tx != 1'b1)});
                    k = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic model_parity(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) if (d[i]) ones++;
        return (ones % 2) != 0;
    endfunction

    // Present a byte in an idle cycle; returns just before the first START clock.
    task automatic start_accept(input logic [7:0] d);
        @(negedge clk);
        bus.tx_valid = 1'b1;
        bus.tx_data  = d;
        chk("accept_ready", bus.tx_ready, 1);
        chk("idle_busy", tx_busy, 0);
        chk("idle_tx", tx, 1);
        @(posedge clk);
        #1;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'($urandom);
        if (c_fifo) @(posedge clk);
    endtask

    // Compare every clock of a frame with {stop, parity, data, start} bit times.
    task automatic check_frame(input logic [7:0] d, input logic p,
                               input bit hold, input logic [7:0] hd);
        logic [10:0] bits;
        rx_rec_t     rec;
        bits = {1'b1, p, d, 1'b0};
        for (int k = 1; k <= c_frame_clks; k++) begin
            @(negedge clk);
            if (hold && k == 1) begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = hd;
            end
            chk("frame_tx", tx, bits[(k - 1) / c_bit_clks]);
            chk("frame_done", tx_done, (k == c_frame_clks) ? 1 : 0);
            chk("frame_busy", tx_busy, 1);
            chk("frame_ready", bus.tx_ready, c_fifo ? 1 : 0);
        end
        chk("rx_count", rx_q.size() > 0 ? 1 : 0, 1);
        if (rx_q.size() > 0) begin
            rec = rx_q.pop_front();
            chk("rx_data", rec.data, d);
            chk("rx_parity_err", rec.perr, 0);
            chk("rx_frame_err", rec.ferr, 0);
        end
    endtask

    initial begin
        vec_t       vecs[9];
        logic [7:0] d;
        int         gap;

        vecs[0] = '{8'hA5, 1'b0};
        vecs[1] = '{8'h07, 1'b1};
        vecs[2] = '{8'h00, 1'b0};
        vecs[3] = '{8'hFF, 1'b0};
        vecs[4] = '{8'h01, 1'b1};
        vecs[5] = '{8'h80, 1'b1};
        vecs[6] = '{8'h3C, 1'b0};
        vecs[7] = '{8'h55, 1'b0};
        vecs[8] = '{8'h6E, 1'b1};

        n_checks     = 0;
        n_fail       = 0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        reset        = 1'b1;
        #1 reset     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_done", tx_done, 0);
        reset = 1'b1;
        #1;
        chk("post_rst_tx", tx, 1);
        chk("post_rst_ready", bus.tx_ready, 1);
        chk("post_rst_busy", tx_busy, 0);
        chk("post_rst_done", tx_done, 0);

        foreach (vecs[i]) begin
            start_accept(vecs[i].data);
            check_frame(vecs[i].data, vecs[i].exp_par, 1'b0, 8'h00);
        end

        for (int r = 0; r < 4; r++) begin
            d   = 8'($urandom);
            gap = int'($urandom_range(0, 3));
            repeat (gap) begin
                @(negedge clk);
                chk("gap_tx", tx, 1);
                chk("gap_busy", tx_busy, 0);
            end
            start_accept(d);
            check_frame(d, model_parity(d), 1'b0, 8'h00);
        end

`ifndef UART_TX_FIFO_EN
        // Byte held during a frame is taken in the idle clock after tx_done.
        start_accept(8'hA5);
        check_frame(8'hA5, 1'b0, 1'b1, 8'h3C);
        start_accept(8'h3C);
        check_frame(8'h3C, 1'b0, 1'b0, 8'h00);
`endif

        // Abort a frame at clock 45, while the line is low.
        start_accept(8'h00);
        repeat (44) @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_tx", tx, 1);
        chk("abort_busy", tx_busy, 0);
        chk("abort_done", tx_done, 0);
        chk("abort_ready", bus.tx_ready, 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_rx", rx_q.size(), 0);
        rx_q.delete();
        start_accept(8'h55);
        check_frame(8'h55, 1'b0, 1'b0, 8'h00);

`ifdef UART_TX_FIFO_EN
        begin
            logic [7:0] fb[5];
            int         idx;
            bit         saw_full;
            int         done_t[$];
            rx_rec_t    rec;
            fb       = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
            idx      = 0;
            saw_full = 1'b0;
            rx_q.delete();
            for (int cyc = 0; cyc < 800 && done_t.size() < 5; cyc++) begin
                @(negedge clk);
                if (idx < 5) begin
                    bus.tx_valid = 1'b1;
                    bus.tx_data  = fb[idx];
                end else begin
                    bus.tx_valid = 1'b0;
                end
                if (tx_done) done_t.push_back(cyc);
                if (!bus.tx_ready) saw_full = 1'b1;
                if (bus.tx_valid && bus.tx_ready) idx++;
            end
            bus.tx_valid = 1'b0;
            chk("fifo_pushed", idx, 5);
            chk("fifo_full_seen", saw_full, 1);
            chk("fifo_done_count", done_t.size(), 5);
            for (int i = 1; i < done_t.size(); i++)
                chk("fifo_done_spacing", done_t[i] - done_t[i-1], c_frame_clks);
            chk("fifo_rx_count", rx_q.size(), 5);
            for (int i = 0; i < 5 && rx_q.size() > 0; i++) begin
                rec = rx_q.pop_front();
                chk("fifo_rx_data", rec.data, fb[i]);
                chk("fifo_rx_parity_err", rec.perr, 0);
            end
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
